// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V control unit.
// States, select encodings, opcode classes and the TYPE_* opcode values.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_S,
        CLS_SB,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_ILL
    } op_cls_t;

    typedef enum logic {
        PC_SEL_PC4 = 1'b0,
        PC_SEL_ALU = 1'b1
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_t;

    localparam logic [6:0] TYPE_R     = 7'b0110011;
    localparam logic [6:0] TYPE_I     = 7'b0010011;
    localparam logic [6:0] TYPE_LOAD  = 7'b0000011;
    localparam logic [6:0] TYPE_S     = 7'b0100011;
    localparam logic [6:0] TYPE_SB    = 7'b1100011;
    localparam logic [6:0] TYPE_LUI   = 7'b0110111;
    localparam logic [6:0] TYPE_AUIPC = 7'b0010111;
    localparam logic [6:0] TYPE_JAL   = 7'b1101111;
    localparam logic [6:0] TYPE_JALR  = 7'b1100111;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
    import riscv_ctrl_pkg::*;

    logic [6:0]  opcode;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_we;
    logic        ir_we;
    logic        reg_we;
    logic        pc_we;
    pc_sel_t     pc_sel;
    wb_sel_t     wb_sel;
    logic        halted;
    logic [31:0] instret;

    modport master (
        input  opcode, mem_ready, branch_taken,
        output mem_req, mem_we, ir_we, reg_we, pc_we,
        output pc_sel, wb_sel, halted, instret
    );

    modport slave (
        output opcode, mem_ready, branch_taken,
        input  mem_req, mem_we, ir_we, reg_we, pc_we,
        input  pc_sel, wb_sel, halted, instret
    );

endinterface

// File: rtl/multicycle_ctrl_op_class.sv
// Opcode classifier: maps inst[6:0] to an instruction class.
// Unknown opcodes report CLS_ILL with o_legal low.
module op_class
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_cls_t    o_cls,
    output logic       o_legal
);

    always_comb begin
        o_cls   = CLS_ILL;
        o_legal = 1'b1;
        unique case (1'b1)
            (i_opcode == TYPE_R):     o_cls = CLS_R;
            (i_opcode == TYPE_I):     o_cls = CLS_I;
            (i_opcode == TYPE_LOAD):  o_cls = CLS_LOAD;
            (i_opcode == TYPE_S):     o_cls = CLS_S;
            (i_opcode == TYPE_SB):    o_cls = CLS_SB;
            (i_opcode == TYPE_LUI):   o_cls = CLS_LUI;
            (i_opcode == TYPE_AUIPC): o_cls = CLS_AUIPC;
            (i_opcode == TYPE_JAL):   o_cls = CLS_JAL;
            (i_opcode == TYPE_JALR):  o_cls = CLS_JALR;
            default:                  o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT.
// Enables are gated by rst so an asserted reset drops them at once.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_op_q;
    logic [31:0] r_instret;

    logic [6:0] w_op_src;
    op_cls_t    w_cls;
    logic       w_legal;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_ir_we;
    logic       w_reg_we;
    logic       w_pc_we;
    pc_sel_t    w_pc_sel;
    wb_sel_t    w_wb_sel;
    logic       w_halted;

    // DECODE classifies the live opcode; later states use the latched one.
    assign w_op_src = (r_state == S_DECODE) ? bus.opcode : r_op_q;

    op_class u_op_class (
        .i_opcode (w_op_src),
        .o_cls    (w_cls),
        .o_legal  (w_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_op_q    <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_op_q <= bus.opcode;
            if (w_pc_we)
                r_instret <= r_instret + 32'd1;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
        w_ir_we   = 1'b0;
        w_reg_we  = 1'b0;
        w_pc_we   = 1'b0;
        w_pc_sel  = PC_SEL_PC4;
        w_wb_sel  = WB_ALU;
        w_halted  = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = w_legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                unique case (w_cls)
                    CLS_LOAD, CLS_S: w_next = S_MEM;
                    CLS_SB: begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = pc_sel_t'(bus.branch_taken);
                        w_next   = S_FETCH;
                    end
                    default: w_next = S_WB;
                endcase
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (w_cls == CLS_S);
                if (bus.mem_ready) begin
                    if (w_cls == CLS_S) begin
                        w_pc_we = 1'b1;
                        w_next  = S_FETCH;
                    end else begin
                        w_next  = S_WB;
                    end
                end
            end
            S_WB: begin
                w_reg_we = 1'b1;
                w_pc_we  = 1'b1;
                w_next   = S_FETCH;
                if (w_cls == CLS_LOAD)
                    w_wb_sel = WB_MEM;
                else if (w_cls == CLS_JAL || w_cls == CLS_JALR) begin
                    w_wb_sel = WB_PC4;
                    w_pc_sel = PC_SEL_ALU;
                end
            end
            S_HALT: w_halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
        if (rst) begin
            w_mem_req = 1'b0;
            w_mem_we  = 1'b0;
            w_ir_we   = 1'b0;
            w_reg_we  = 1'b0;
            w_pc_we   = 1'b0;
            w_halted  = 1'b0;
        end
    end

    assign bus.mem_req = w_mem_req;
    assign bus.mem_we  = w_mem_we;
    assign bus.ir_we   = w_ir_we;
    assign bus.reg_we  = w_reg_we;
    assign bus.pc_we   = w_pc_we;
    assign bus.pc_sel  = w_pc_sel;
    assign bus.wb_sel  = w_wb_sel;
    assign bus.halted  = w_halted;
    assign bus.instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: driver queues per-cycle
// expectations, monitor pops and compares mid-cycle.
module tb_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    logic clk;
    logic rst;
    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // e bits: mem_req mem_we ir_we reg_we pc_we pc_sel wb_sel[1:0] halted
    typedef struct {
        string       nm;
        logic [8:0]  e;
        logic [31:0] ins;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_instret = 32'd0;

    task automatic compare(input string nm, input logic [8:0] e,
                           input logic [31:0] ins);
        logic [8:0] act;
        logic [8:0] mask;
        act = {bus.mem_req, bus.mem_we, bus.ir_we, bus.reg_we,
               bus.pc_we, bus.pc_sel, bus.wb_sel, bus.halted};
        mask = 9'b1_1111_0001;
        if (e[4]) mask[3] = 1'b1;
        if (e[5]) mask[2:1] = 2'b11;
        checks++;
        if (((act & mask) != (e & mask)) || (bus.instret !== ins)) begin
            failures++;
            $display("FAIL %s: ctl=%b instret=%h expected ctl=%b instret=%h",
                     nm, act & mask, bus.instret, e & mask, ins);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            compare(x.nm, x.e, x.ins);
        end
    end

    task automatic step(input string nm, input logic r, input logic [6:0] op,
                        input logic mr, input logic bt, input logic [8:0] e);
        @(negedge clk);
        rst = r;
        bus.opcode = op;
        bus.mem_ready = mr;
        bus.branch_taken = bt;
        if (r) exp_instret = 32'd0;
        q.push_back('{nm, e, exp_instret});
        if (e[4]) exp_instret = exp_instret + 32'd1;
    endtask

    task automatic run_instr(input string nm, input logic [6:0] op,
                             input int fw, input int mw, input logic bt);
        for (int i = 0; i < fw; i++)
            step({nm, "_fwait"}, 1'b0, op, 1'b0, bt, 9'b1_0000_0000);
        step({nm, "_fetch"}, 1'b0, op, 1'b1, bt, 9'b1_0100_0000);
        step({nm, "_decode"}, 1'b0, op, 1'b1, bt, 9'b0);
        if (op == TYPE_SB) begin
            step({nm, "_exec"}, 1'b0, op, 1'b1, bt, {4'b0, 1'b1, bt, 3'b000});
        end else if (op == TYPE_LOAD || op == TYPE_S) begin
            logic st;
            st = (op == TYPE_S);
            step({nm, "_exec"}, 1'b0, op, 1'b1, bt, 9'b0);
            for (int i = 0; i < mw; i++)
                step({nm, "_mwait"}, 1'b0, op, 1'b0, bt, {1'b1, st, 7'b0});
            if (st)
                step({nm, "_mem"}, 1'b0, op, 1'b1, bt, 9'b1_1001_0000);
            else begin
                step({nm, "_mem"}, 1'b0, op, 1'b1, bt, 9'b1_0000_0000);
                step({nm, "_wb"}, 1'b0, op, 1'b1, bt, 9'b0_0011_0010);
            end
        end else begin
            logic j;
            j = (op == TYPE_JAL || op == TYPE_JALR);
            step({nm, "_exec"}, 1'b0, op, 1'b1, bt, 9'b0);
            step({nm, "_wb"}, 1'b0, op, 1'b1, bt,
                 {5'b0_0011, j, j, 2'b00});
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.opcode = 7'd0;
        bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b0;

        step("reset0", 1'b1, 7'd0, 1'b1, 1'b0, 9'b0);
        step("reset1", 1'b1, 7'd0, 1'b1, 1'b0, 9'b0);

        run_instr("R", 7'b0110011, 0, 0, 1'b0);
        run_instr("LOAD", TYPE_LOAD, 0, 2, 1'b0);
        run_instr("S", TYPE_S, 1, 1, 1'b0);
        run_instr("SB_t", TYPE_SB, 0, 0, 1'b1);
        run_instr("SB_nt", TYPE_SB, 0, 0, 1'b0);
        run_instr("I", TYPE_I, 0, 0, 1'b1);
        run_instr("LUI", TYPE_LUI, 0, 0, 1'b0);
        run_instr("AUIPC", TYPE_AUIPC, 0, 0, 1'b0);
        run_instr("JALR", TYPE_JALR, 0, 0, 1'b0);

        // JAL with instret preloaded to all-ones
        step("jal_fetch", 1'b0, TYPE_JAL, 1'b1, 1'b0, 9'b1_0100_0000);
        step("jal_decode", 1'b0, TYPE_JAL, 1'b1, 1'b0, 9'b0);
        #3;
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        exp_instret = 32'hFFFF_FFFF;
        step("jal_exec", 1'b0, TYPE_JAL, 1'b1, 1'b0, 9'b0);
        step("jal_wb", 1'b0, TYPE_JAL, 1'b1, 1'b0, 9'b0_0011_1100);
        step("wrap_fetch", 1'b0, TYPE_S, 1'b1, 1'b0, 9'b1_0100_0000);

        // store interrupted by reset while writing
        step("st_decode", 1'b0, TYPE_S, 1'b1, 1'b0, 9'b0);
        step("st_exec", 1'b0, TYPE_S, 1'b1, 1'b0, 9'b0);
        step("st_mem", 1'b0, TYPE_S, 1'b0, 1'b0, 9'b1_1000_0000);
        #4;
        rst = 1'b1;
        #1;
        exp_instret = 32'd0;
        compare("st_async_rst", 9'b0, 32'd0);
        step("st_rst", 1'b1, TYPE_S, 1'b0, 1'b0, 9'b0);
        step("st_restart", 1'b0, TYPE_S, 1'b0, 1'b0, 9'b1_0000_0000);

        // illegal opcode halts until reset
        step("ill_fetch", 1'b0, 7'b1111111, 1'b1, 1'b0, 9'b1_0100_0000);
        step("ill_decode", 1'b0, 7'b1111111, 1'b1, 1'b0, 9'b0);
        for (int i = 0; i < 3; i++)
            step("halt", 1'b0, TYPE_R, 1'b1, 1'b1, 9'b0_0000_0001);
        step("halt_rst", 1'b1, TYPE_R, 1'b1, 1'b0, 9'b0);
        run_instr("R_after", TYPE_R, 0, 0, 1'b0);

        @(negedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: left=%0d expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port opcode, input, 7 bits: inst[6:0] from the instruction register.
REQ-004 SHALL have port mem_ready, input, 1 bit: the shared memory port completes the current request this cycle.
REQ-005 SHALL have port branch_taken, input, 1 bit: the datapath's branch compare result.
REQ-006 SHALL have ports mem_req and mem_we, outputs, 1 bit each: memory request and write enable.
REQ-007 SHALL have ports ir_we, reg_we and pc_we, outputs, 1 bit each: write enables for the instruction register, the register file and the PC.
REQ-008 SHALL have port pc_sel, output, 1 bit: 0 selects PC+4, 1 selects the ALU target.
REQ-009 SHALL have port wb_sel, output, 2 bits: 00 selects ALU, 01 selects memory data, 10 selects PC+4.
REQ-010 SHALL have port halted, output, 1 bit: set after an illegal opcode.
REQ-011 SHALL have port instret, output, 32 bits: retired-instruction counter.

Function
REQ-012 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-013 FETCH SHALL assert mem_req=1 and mem_we=0; on mem_ready it SHALL pulse ir_we and move to DECODE, otherwise it SHALL hold.
REQ-014 DECODE SHALL latch opcode into op_q, then go to EXEC if the opcode is in {R 0110011, I 0010011, LOAD 0000011, S 0100011, SB 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111}; any other opcode SHALL go to HALT.
REQ-015 EXEC, driven by op_q, SHALL behave as follows:
- LOAD and S: go to MEM.
- SB: assert pc_we with pc_sel=branch_taken, then go to FETCH.
- All other legal classes: go to WB.
REQ-016 MEM SHALL assert mem_req, with mem_we=1 only for S, and hold until mem_ready. On mem_ready:
- S: assert pc_we with pc_sel=0, then go to FETCH.
- LOAD: go to WB.
REQ-017 WB SHALL assert reg_we and pc_we, then go to FETCH, with the following selects:
- wb_sel: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
- pc_sel: 1 for JAL/JALR, 0 otherwise.
REQ-018 HALT SHALL set halted=1, hold all enables at 0, and stay there until reset.
REQ-019 Outputs SHALL be combinational from state, op_q and mem_ready (Mealy only on mem_ready and branch_taken); all enables SHALL be 0 in any state not listed above.
REQ-020 instret SHALL increment by 1 on every cycle with pc_we=1 and SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 With zero-wait memory, each class SHALL take exactly the following number of cycles:
- R, I, LUI, AUIPC, JAL, JALR: 4.
- LOAD: 5.
- S: 4.
- SB: 3.
REQ-022 Each wait cycle in FETCH or MEM SHALL add exactly one cycle, with no spurious enables.

Reset
REQ-023 While rst=1, the block SHALL hold state=FETCH, op_q=0, instret=0 and halted=0, and SHALL force every enable and mem_req to 0.
REQ-024 mem_req SHALL assert in the first cycle after rst deasserts.
REQ-025 Reset asserted mid-instruction, including in MEM with mem_we=1, SHALL drop all enables in the same cycle, asynchronously.

Structure
REQ-026 Package riscv_ctrl_pkg SHALL hold the state enum, the pc_sel and wb_sel encodings, and the opcode constants, reusing the existing TYPE_* opcode values.
REQ-027 Sub-module op_class (combinational: opcode to class enum plus a legal flag) SHALL be instantiated once.

Verification
REQ-028 R-type 0x002081B3 with mem_ready held 1 -> ir_we in cycle 1; reg_we=1, wb_sel=00, pc_we=1, pc_sel=0 in cycle 4; instret=1.
REQ-029 LOAD opcode 0000011 with mem_ready=0 for 2 cycles in MEM -> mem_req=1 and mem_we=0 for 3 MEM cycles; WB with wb_sel=01 in cycle 7.
REQ-030 SB opcode 1100011 with branch_taken=1 -> pc_we=1 and pc_sel=1 in cycle 3; with branch_taken=0 -> pc_sel=0; reg_we never asserts.
REQ-031 Opcode 1111111 -> halted=1 from cycle 3; no further mem_req; rst pulse -> mem_req=1 in the next cycle.
REQ-032 instret preloaded to 0xFFFFFFFF (forced), then one JAL -> instret=0, wb_sel=10, pc_sel=1.
REQ-033 rst asserted during a store in MEM -> mem_we and mem_req drop to 0 immediately; after release, the block restarts at FETCH.
